c_join_ctrl: RTL
================

Name: c_join_ctrl

Overview:
Synchronous four-phase join controller that sequences a shared C-element-style rendezvous.
- Two upstream requesters (A, B) each run a return-to-zero req/ack handshake.
- One downstream channel is raised only when both requests are high, and returned to zero only when both are low (Muller C semantics).
- The downstream acknowledge is forked back to both requesters.
- Also provides protocol-violation and timeout detection plus a completed-transaction counter, for use as the sequencing front-end of the C-element pipeline stages.

Parameters:
TO_W, 8, width of the acknowledge-timeout counter.
TIMEOUT, 200, cycles waited for ack_i in RISE or FALL before err_to is set (1..2^TO_W-1).
CNT_W, 16, width of the completed-transaction counter.

Ports:
clk  input  1  clock, all state updates on rising edge.
r  input  1  reset, asynchronous, active-high.
req_a  input  1  four-phase request from requester A.
req_b  input  1  four-phase request from requester B.
ack_a  output  1  acknowledge to A.
ack_b  output  1  acknowledge to B.
req_o  output  1  downstream four-phase request.
ack_i  input  1  downstream acknowledge.
clr_err  input  1  one-cycle pulse that clears the sticky error flags.
err_proto  output  1  sticky protocol-violation flag.
err_to  output  1  sticky ack-timeout flag.
count  output  CNT_W  number of completed four-phase cycles.

Behaviour:
- All outputs are registered. Inputs are sampled on the rising clk edge, and output changes appear on the same edge the state transition occurs.
- Reset (asynchronous, any time, including mid-handshake) drives:
  - state=IDLE
  - req_o=0, ack_a=0, ack_b=0
  - err_proto=0, err_to=0
  - count=0
  - timeout counter=0
- FSM states and outputs:
  - IDLE: req_o=0, acks=0.
  - RISE: req_o=1, acks=0.
  - HELD: req_o=1, acks=1.
  - FALL: req_o=0, acks=1.
- IDLE -> RISE when req_a&req_b=1. If only one request is high, remain in IDLE (C-element hold).
- RISE -> HELD when ack_i=1.
- HELD -> FALL when req_a|req_b=0. If only one request is low, remain in HELD.
- FALL -> IDLE when ack_i=0. Increment count on this transition; it wraps from 2^CNT_W-1 to 0.
- Latency: the first edge sampling both requests high raises req_o; the first edge sampling ack_i=1 raises both acks.
- Timeout counter:
  - Cleared on entry to RISE and on entry to FALL.
  - Increments each cycle while in RISE or FALL, saturating.
  - When it reaches TIMEOUT, set err_to. The FSM keeps waiting; no abort.
- err_proto is set when any of the following is sampled:
  - ack_i=1 while in IDLE;
  - req_a or req_b low while in RISE;
  - ack_i=0 while in HELD.
- In every error case the FSM ignores the violation and follows the normal transition rules only.
- Sticky flags:
  - Flags clear on clr_err.
  - If set and clear occur in the same cycle, set wins.
  - clr_err has no effect on state or count.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RISE=2'd1, HELD=2'd2, FALL=2'd3;
  - default TIMEOUT and width constants.
- One natural sub-module: c_join_timer. It is the saturating TO_W-bit counter with clear/enable inputs and a reached-TIMEOUT output.

Test Plan:
1. Reset, then req_a=1 only for 5 cycles -> req_o=0, acks=0. Set req_b=1 -> req_o=1 one edge later.
2. Full cycle: both reqs high, ack_i=1 -> ack_a=ack_b=1. Then:
   - drop req_a only -> req_o stays 1;
   - drop req_b -> req_o=0;
   - ack_i=0 -> acks=0 and count=1.
   Repeat 3 times -> count=4.
3. Hold ack_i=0 in RISE with TIMEOUT=4 -> err_to=1 exactly 4 cycles after RISE entry. Then ack_i=1 -> HELD reached normally. Pulse clr_err -> err_to=0.
4. Violations:
   - ack_i=1 in IDLE -> err_proto=1, req_o remains 0.
   - After clr_err, drop req_b during RISE -> err_proto=1, state stays RISE until ack_i=1.
5. Assert r while in HELD with count=3 -> immediately req_o=0, acks=0, count=0, flags 0. Release r with both reqs high -> req_o=1 on the first edge.
6. Assert clr_err in the same cycle a new violation is detected -> err_proto reads 1. With CNT_W=2, run 4 full cycles -> count wraps to 0.

Source files
------------

// File: rtl/c_join_pkg.sv
// Shared types and defaults for the four-phase join controller.
// The state encoding is fixed so external checkers can decode dbg_state.
package c_join_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HELD = 2'd2,
    FALL = 2'd3
  } state_e;

  localparam int unsigned DEF_TO_W    = 8;
  localparam int unsigned DEF_TIMEOUT = 200;
  localparam int unsigned DEF_CNT_W   = 16;

  // RISE and FALL are the two states that wait on the downstream acknowledge.
  function automatic logic is_wait(input state_e s);
    return (s == RISE) || (s == FALL);
  endfunction

endpackage

// File: rtl/c_join_timer.sv
// Saturating acknowledge-wait counter.
// hit_o pulses on the single increment that lands exactly on TIMEOUT.
module c_join_timer #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [TO_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0] TO_M1   = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    hit_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + TO_W'(1);
      hit_o = (cnt_q == TO_M1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/c_join_ctrl.sv
// Four-phase join: req_o rises only when both requests are high and falls only
// when both are low; the downstream ack is forked back to both requesters.
module c_join_ctrl
  import c_join_pkg::*;
#(
  parameter int unsigned TO_W    = DEF_TO_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             r,
  input  logic             req_a,
  input  logic             req_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             req_o,
  input  logic             ack_i,
  input  logic             clr_err,
  output logic             err_proto,
  output logic             err_to,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       dbg_state
);

  // Handshake: every channel is return-to-zero. A req may only rise after its
  // ack is low and only fall after its ack is high; an ack follows its req.
  state_e           state_q;
  state_e           state_d;
  logic             req_o_q;
  logic             req_o_d;
  logic             ack_q;
  logic             ack_d;
  logic             err_proto_q;
  logic             err_proto_d;
  logic             err_to_q;
  logic             err_to_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             proto_set;
  logic             tmr_clr;
  logic             tmr_en;
  logic             to_hit;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q     <= IDLE;
      req_o_q     <= 1'b0;
      ack_q       <= 1'b0;
      err_proto_q <= 1'b0;
      err_to_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_o_q     <= req_o_d;
      ack_q       <= ack_d;
      err_proto_q <= err_proto_d;
      err_to_q    <= err_to_d;
      count_q     <= count_d;
    end
  end

  // Violations never redirect the FSM; they only raise the sticky flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_a && req_b)   state_d = RISE;
      RISE:    if (ack_i)            state_d = HELD;
      HELD:    if (!req_a && !req_b) state_d = FALL;
      FALL:    if (!ack_i)           state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_comb begin
    req_o_d   = (state_d == RISE) || (state_d == HELD);
    ack_d     = (state_d == HELD) || (state_d == FALL);
    proto_set = 1'b0;
    case (state_q)
      IDLE:    proto_set = ack_i;
      RISE:    proto_set = !req_a || !req_b;
      HELD:    proto_set = !ack_i;
      default: proto_set = 1'b0;
    endcase
    err_proto_d = proto_set | (err_proto_q & ~clr_err);
    err_to_d    = to_hit | (err_to_q & ~clr_err);
    count_d     = ((state_q == FALL) && !ack_i) ? count_q + CNT_W'(1) : count_q;
  end

  assign tmr_clr = (state_d != state_q) && is_wait(state_d);
  assign tmr_en  = is_wait(state_q);

  c_join_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (r),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .hit_o (to_hit)
  );

  assign req_o     = req_o_q;
  assign ack_a     = ack_q;
  assign ack_b     = ack_q;
  assign err_proto = err_proto_q;
  assign err_to    = err_to_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule
